// File: rtl/sgd_dot_recv_unpack.sv
// Reassembles per-bank dot-product results arriving as RX beats into full
// NUM_BANKS-wide vectors and queues them in a small first-word-fall-through FIFO.
module sgd_dot_recv_unpack #(
   parameter  int NUM_BANKS = 8,
   parameter  int RESULT_W  = 32,
   parameter  int DATA_W    = 64,
   parameter  int DEPTH     = 4,
   localparam int VEC_W     = NUM_BANKS * RESULT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_meta_valid,
   output logic              s_meta_ready,
   input  logic [47:0]       s_meta_data,
   input  logic              s_data_valid,
   output logic              s_data_ready,
   input  logic [DATA_W-1:0] s_data_data,
   input  logic              s_data_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [VEC_W-1:0]  m_data,
   output logic [31:0]       vec_count,
   output logic [15:0]       drop_count
);

   localparam int BEATS     = VEC_W / DATA_W;
   localparam int VEC_BYTES = VEC_W / 8;
   localparam int BI_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PW        = $clog2(DEPTH);
   localparam int CW        = PW + 1;

   typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

   state_t                       state_q, state_d;
   logic [BI_W-1:0]              beat_idx_q, beat_idx_d;
   logic [15:0]                  vec_rem_q, vec_rem_d;
   logic [VEC_W-1:0]             vec_buf_q, vec_buf_d;
   logic [DEPTH-1:0][VEC_W-1:0]  mem_q, mem_d;
   logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic [31:0]                  vec_count_q, vec_count_d;
   logic [15:0]                  drop_count_q, drop_count_d;

   logic              fifo_full, meta_hs, data_hs, push, pop, drop_inc;
   logic [15:0]       len;
   logic [VEC_W-1:0]  asm_vec;
   logic              meta_unused;

   assign meta_unused = ^s_meta_data[47:16];
   assign len         = s_meta_data[15:0];
   assign fifo_full   = (cnt_q == CW'(DEPTH));
   assign m_valid     = (cnt_q != '0);
   assign m_data      = mem_q[rd_ptr_q];
   assign vec_count   = vec_count_q;
   assign drop_count  = drop_count_q;

   always_comb begin
      state_d      = state_q;
      beat_idx_d   = beat_idx_q;
      vec_rem_d    = vec_rem_q;
      vec_buf_d    = vec_buf_q;
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      cnt_d        = cnt_q;
      vec_count_d  = vec_count_q;
      drop_count_d = drop_count_q;
      push         = 1'b0;
      drop_inc     = 1'b0;

      s_meta_ready = (state_q == IDLE);
      s_data_ready = (state_q == DRAIN) || ((state_q == RECV) && !fifo_full);
      meta_hs      = s_meta_valid && s_meta_ready;
      data_hs      = s_data_valid && s_data_ready;
      pop          = m_valid && m_ready;

      // The completing beat is merged combinationally so it can be pushed directly.
      asm_vec = vec_buf_q;
      asm_vec[beat_idx_q*DATA_W +: DATA_W] = s_data_data;

      case (state_q)
         IDLE: begin
            if (meta_hs) begin
               if ((len == 16'd0) || ((32'(len) % VEC_BYTES) != 0)) begin
                  state_d  = DRAIN;
                  drop_inc = 1'b1;
               end else begin
                  vec_rem_d  = 16'(32'(len) / VEC_BYTES);
                  beat_idx_d = '0;
                  state_d    = RECV;
               end
            end
         end
         RECV: begin
            if (data_hs) begin
               vec_buf_d = asm_vec;
               if (beat_idx_q == BI_W'(BEATS - 1)) begin
                  push       = 1'b1;
                  beat_idx_d = '0;
                  vec_rem_d  = vec_rem_q - 16'd1;
                  if (vec_rem_q == 16'd1) begin
                     state_d  = s_data_last ? IDLE : DRAIN;
                     drop_inc = !s_data_last;
                  end else if (s_data_last) begin
                     state_d  = IDLE;
                     drop_inc = 1'b1;
                  end
               end else if (s_data_last) begin
                  // Short packet: partial vector is simply abandoned.
                  beat_idx_d = '0;
                  state_d    = IDLE;
                  drop_inc   = 1'b1;
               end else begin
                  beat_idx_d = beat_idx_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (data_hs && s_data_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (push) begin
         mem_d[wr_ptr_q] = asm_vec;
         wr_ptr_d        = wr_ptr_q + 1'b1;
         vec_count_d     = vec_count_q + 32'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      if (drop_inc && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         beat_idx_q   <= '0;
         vec_rem_q    <= '0;
         vec_buf_q    <= '0;
         mem_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         vec_count_q  <= '0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         beat_idx_q   <= beat_idx_d;
         vec_rem_q    <= vec_rem_d;
         vec_buf_q    <= vec_buf_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         vec_count_q  <= vec_count_d;
         drop_count_q <= drop_count_d;
      end
   end

endmodule

// File: tb/tb_sgd_dot_recv_unpack.sv
// Directed + random bench for sgd_dot_recv_unpack; expected vectors and counters
// come from a packet-level model (vectors = complete groups of beats, drop on any length mismatch).
module tb_sgd_dot_recv_unpack;

   localparam int NB    = 8;
   localparam int RW    = 32;
   localparam int DW    = 64;
   localparam int DEPTH = 4;
   localparam int VW    = NB * RW;
   localparam int BEATS = VW / DW;
   localparam int VB    = VW / 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_meta_valid = 1'b0;
   logic          s_meta_ready;
   logic [47:0]   s_meta_data = '0;
   logic          s_data_valid = 1'b0;
   logic          s_data_ready;
   logic [DW-1:0] s_data_data = '0;
   logic          s_data_last = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [VW-1:0] m_data;
   logic [31:0]   vec_count;
   logic [15:0]   drop_count;

   sgd_dot_recv_unpack #(.NUM_BANKS(NB), .RESULT_W(RW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready), .s_meta_data(s_meta_data),
      .s_data_valid(s_data_valid), .s_data_ready(s_data_ready), .s_data_data(s_data_data),
      .s_data_last(s_data_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .vec_count(vec_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   logic [VW-1:0] exp_q[$];
   logic [DW-1:0] beats[$];
   int unsigned   m_vec = 0;
   int            m_drop = 0;
   logic          rdy_force = 1'b0;
   logic          rdy_rand = 1'b0;

   always @(posedge clk) begin
      #2;
      m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
   end

   task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every accepted output vector must be the next one the model predicted.
   always @(negedge clk) begin
      if (rst_n && m_valid === 1'b1 && m_ready === 1'b1) begin
         chk("vec_expected", VW'(exp_q.size() != 0), VW'(1));
         if (exp_q.size() != 0) chk("vec_data", m_data, exp_q.pop_front());
      end
   end

   task automatic fill_rand(input int n);
      beats.delete();
      for (int i = 0; i < n; i++) beats.push_back({$urandom, $urandom});
   endtask

   task automatic model_pkt(input logic [15:0] len, input int n);
      int nv;
      logic [VW-1:0] v;
      if (len == 0 || (len % VB) != 0) begin
         if (m_drop < 65535) m_drop++;
         return;
      end
      nv = n / BEATS;
      if (nv > len / VB) nv = len / VB;
      for (int k = 0; k < nv; k++) begin
         v = '0;
         for (int b = 0; b < BEATS; b++) v[b*DW +: DW] = beats[k*BEATS + b];
         exp_q.push_back(v);
         m_vec++;
      end
      if (n != (len / VB) * BEATS && m_drop < 65535) m_drop++;
   endtask

   task automatic send_meta(input logic [15:0] len);
      int n = 0;
      bit ok = 0;
      s_meta_valid = 1'b1;
      s_meta_data  = {$urandom, len};
      while (n < 1000 && !ok) begin
         @(negedge clk);
         if (s_meta_ready) begin ok = 1; @(posedge clk); #1; end
         else n++;
      end
      if (!ok) chk("meta_hs_timeout", VW'(ok), VW'(1));
      s_meta_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic last, inout int stalls);
      int n = 0;
      bit ok = 0;
      s_data_valid = 1'b1;
      s_data_data  = d;
      s_data_last  = last;
      while (n < 1000 && !ok) begin
         @(negedge clk);
         if (s_data_ready) begin ok = 1; @(posedge clk); #1; end
         else n++;
      end
      stalls += n;
      if (!ok) chk("data_hs_timeout", VW'(ok), VW'(1));
      s_data_valid = 1'b0;
      s_data_last  = 1'b0;
   endtask

   task automatic send_pkt(input logic [15:0] len, input int n, inout int stalls);
      model_pkt(len, n);
      send_meta(len);
      for (int i = 0; i < n; i++) send_beat(beats[i], 1'(i == n - 1), stalls);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (n < 2000 && exp_q.size() != 0) begin @(posedge clk); n++; end
      repeat (2) @(posedge clk);
      #1;
      chk("drain_empty", VW'(exp_q.size()), VW'(0));
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, "_vec_count"}, VW'(vec_count), VW'(m_vec));
      chk({tag, "_drop_count"}, VW'(drop_count), VW'(m_drop));
   endtask

   initial begin
      int st;
      logic [VW-1:0] v;
      logic [15:0] len;
      int need, n;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_m_valid", VW'(m_valid), VW'(0));
      chk("rst_m_data", m_data, '0);
      chk_counts("rst");
      chk("rst_meta_ready", VW'(s_meta_ready), VW'(1));
      chk("rst_data_ready", VW'(s_data_ready), VW'(0));

      // Single vector, bank i carries value i, one-cycle latency to m_valid.
      rdy_force = 1'b1;
      beats.delete();
      for (int i = 0; i < BEATS; i++) beats.push_back({32'(2*i + 1), 32'(2*i)});
      v = '0;
      for (int i = 0; i < NB; i++) v[i*RW +: RW] = RW'(i);
      st = 0;
      send_pkt(16'd32, 4, st);
      chk("t1_valid_latency", VW'(m_valid), VW'(1));
      chk("t1_banks", m_data, v);
      @(posedge clk); #1;
      chk("t1_valid_pulse", VW'(m_valid), VW'(0));
      chk_counts("t1");

      // Three vectors buffered with m_ready low, no back-pressure.
      rdy_force = 1'b0;
      @(posedge clk); #1;
      fill_rand(12);
      st = 0;
      send_pkt(16'd96, 12, st);
      chk("t2_no_stall", VW'(st), VW'(0));
      chk("t2_valid_held", VW'(m_valid), VW'(1));
      rdy_force = 1'b1;
      wait_drain();
      chk_counts("t2");

      // Five vectors against a four-deep FIFO.
      rdy_force = 1'b0;
      @(posedge clk); #1;
      fill_rand(20);
      model_pkt(16'd160, 20);
      send_meta(16'd160);
      st = 0;
      for (int i = 0; i < 16; i++) send_beat(beats[i], 1'b0, st);
      chk("t3_first4_no_stall", VW'(st), VW'(0));
      s_data_valid = 1'b1;
      s_data_data  = beats[16];
      @(negedge clk);
      chk("t3_full_ready0_a", VW'(s_data_ready), VW'(0));
      @(negedge clk);
      chk("t3_full_ready0_b", VW'(s_data_ready), VW'(0));
      @(posedge clk); #1 rdy_force = 1'b1;
      @(posedge clk); #1 rdy_force = 1'b0;
      for (int i = 16; i < 20; i++) send_beat(beats[i], 1'(i == 19), st);
      chk("t3_vec_before_drain", VW'(vec_count), VW'(m_vec));
      chk("t3_remaining", VW'(exp_q.size()), VW'(4));
      rdy_force = 1'b1;
      wait_drain();
      chk("t3_valid_idle", VW'(m_valid), VW'(0));
      chk_counts("t3");

      // Length not a vector multiple: drained and counted, next packet fine.
      fill_rand(3);
      st = 0;
      send_pkt(16'd20, 3, st);
      chk("t4_no_stall", VW'(st), VW'(0));
      chk("t4_meta_ready", VW'(s_meta_ready), VW'(1));
      @(posedge clk); #1;
      chk("t4_no_valid", VW'(m_valid), VW'(0));
      chk_counts("t4");
      fill_rand(4);
      send_pkt(16'd32, 4, st);
      wait_drain();
      chk_counts("t4b");

      // Short packet then long packet.
      fill_rand(6);
      send_pkt(16'd64, 6, st);
      wait_drain();
      chk_counts("t5_short");
      fill_rand(6);
      send_pkt(16'd32, 6, st);
      wait_drain();
      chk_counts("t5_long");

      // Reset in the middle of a vector.
      fill_rand(4);
      send_meta(16'd32);
      send_beat(beats[0], 1'b0, st);
      send_beat(beats[1], 1'b0, st);
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      exp_q.delete();
      m_vec = 0;
      m_drop = 0;
      chk("t6_valid", VW'(m_valid), VW'(0));
      chk_counts("t6_rst");
      chk("t6_meta_ready", VW'(s_meta_ready), VW'(1));
      fill_rand(4);
      send_pkt(16'd32, 4, st);
      wait_drain();
      chk_counts("t6_clean");

      // Random packets with random downstream back-pressure.
      rdy_rand = 1'b1;
      for (int p = 0; p < 16; p++) begin
         if ($urandom_range(0, 4) == 0) len = 16'($urandom_range(0, 200));
         else len = 16'(VB * $urandom_range(1, 4));
         need = (len != 0 && (len % VB) == 0) ? (len / VB) * BEATS : 3;
         n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, need + 3) : need;
         fill_rand(n);
         send_pkt(len, n, st);
         chk_counts("rnd");
      end
      rdy_rand = 1'b0;
      rdy_force = 1'b1;
      wait_drain();
      chk_counts("rnd_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sgd_dot_recv_unpack.md
Name: sgd_dot_recv_unpack

Overview:
- Network-side receiver for the SGD worker. Takes packets of per-bank dot-product results (ax-b, sign-shifted) from the TCP/UDP RX stream and reassembles them into full NUM_BANKS-wide result vectors.
- Each packet is one metadata beat plus 1..N data beats. Vectors may span several beats, and one packet may carry several vectors.
- Completed vectors go into an output FIFO with a ready/valid handshake. Malformed packets are drained and counted.

Parameters:
- NUM_BANKS, 8, number of banks per vector.
- RESULT_W, 32, bits per bank result (two's complement).
- DATA_W, 64, RX data beat width. VEC_W = NUM_BANKS*RESULT_W must be an integer multiple of DATA_W; BEATS = VEC_W/DATA_W.
- DEPTH, 4, output FIFO depth in vectors (power of 2, >=2).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- s_meta_valid, in, 1, RX metadata valid.
- s_meta_ready, out, 1, RX metadata ready.
- s_meta_data, in, 48, [15:0] payload length in bytes; [47:16] ignored.
- s_data_valid, in, 1, RX data valid.
- s_data_ready, out, 1, RX data ready.
- s_data_data, in, DATA_W, RX payload beat.
- s_data_last, in, 1, last beat of packet.
- m_valid, out, 1, output vector valid.
- m_ready, in, 1, downstream accept.
- m_data, out, VEC_W, vector; bank i = bits [i*RESULT_W +: RESULT_W].
- vec_count, out, 32, vectors pushed to FIFO; wraps.
- drop_count, out, 16, packets flagged bad; saturates at 0xFFFF.

Behaviour:
- Reset: state IDLE; FIFO empty; m_valid=0; m_data=0; counters 0; beat index and vector-remaining counter 0; partial vector discarded.
- s_meta_ready = (state==IDLE).
- s_data_ready = (state==DRAIN) | (state==RECV & !fifo_full).
- IDLE:
  - On a meta handshake, latch len = s_meta_data[15:0].
  - If len==0 or len % (VEC_W/8) != 0: go to DRAIN and increment drop_count once.
  - Otherwise load vec_rem = len*8/VEC_W, beat_idx=0, and go to RECV.
- RECV: each data handshake writes s_data_data into vector bits [beat_idx*DATA_W +: DATA_W] (first beat = lowest bits), then beat_idx++.
  - Beat with beat_idx==BEATS-1: push the assembled vector, vec_count++, beat_idx=0, vec_rem--.
  - Final vector pushed and last=1: go to IDLE.
  - Final vector pushed and last=0 (packet too long): go to DRAIN, drop_count++. Vectors already pushed stay valid.
  - last=1 before the final vector completes (short packet): discard the partial vector (no push), drop_count++, go to IDLE.
- DRAIN: accept and discard beats until a handshake with last=1, then go to IDLE. Must not stall even when the FIFO is full.
- Latency: vector-completing beat accepted at cycle t; m_valid=1 at t+1 if the FIFO was empty. m_data is registered, first-word-fall-through.
- FIFO:
  - Push and pop in the same cycle are allowed at any occupancy below DEPTH.
  - When full, no push; upstream sees s_data_ready=0 in RECV.
  - m_data and m_valid hold while m_valid & !m_ready.
- Reset mid-packet: all state cleared. Remaining beats of the interrupted packet are ignored until a new meta arrives. Upstream guarantees it will not send further beats without meta, because data ready is 0 in IDLE.
- drop_count saturates; vec_count wraps modulo 2^32.

Test Plan:
- Default params, meta len=32, 4 beats 0x00000001_00000000, 0x00000003_00000002, 0x00000005_00000004, 0x00000007_00000006 with last on beat 4, m_ready=1 -> one m_valid pulse one cycle after beat 4; bank i = i; vec_count=1; drop_count=0.
- len=96, 12 back-to-back beats, m_ready=0 -> 3 vectors buffered, FIFO not yet full, s_data_ready stays 1. Raise m_ready -> 3 vectors out in order, vec_count=3.
- m_ready=0, send 5 vectors (DEPTH=4) -> s_data_ready drops after the 4th vector completes. Release m_ready for 1 cycle -> exactly one more vector is accepted; no data lost or duplicated.
- len=20 (not a multiple of 32), 3 beats with last -> all 3 beats accepted, no m_valid, drop_count=1, returns to IDLE and accepts the next meta.
- len=64 but last on beat 6 -> vector 1 delivered, partial vector 2 discarded, drop_count=1. Repeat with len=32 and last on beat 6 -> vector delivered, beats 5-6 drained, drop_count=2.
- Assert rst_n=0 for one cycle after beat 2 of a vector -> m_valid=0, counters 0. A following clean len=32 packet yields the correct vector with no residue from before reset.
